// File: rtl/mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_pkg : shared FSM encoding and port indices for mem_arbiter       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic PORT0 = 1'b0;
   localparam logic PORT1 = 1'b1;
   localparam int   CNT_W = 4;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arb2 : two-way round-robin pick, one-hot grant                    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rr_arb2
   import mem_pkg::*;
(
   input  logic [1:0] req_i,
   input  logic       last_i,
   output logic [1:0] grant_o
);

   // A lone request wins outright; a tie goes to the port not served last.
   always_comb begin
      grant_o = req_i;
      if (req_i == 2'b11) begin
         grant_o = (last_i == PORT0) ? 2'b10 : 2'b01;
      end
   end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_arbiter : two-port (D$/I$) round-robin arbiter onto one memory   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mem_arbiter
   import mem_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int LINE_W  = 256,
   parameter int TIMEOUT = 15
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              p0_enable_i,
   input  logic              p0_write_i,
   input  logic [ADDR_W-1:0] p0_addr_i,
   input  logic [LINE_W-1:0] p0_data_i,
   output logic              p0_ack_o,
   output logic [LINE_W-1:0] p0_data_o,
   input  logic              p1_enable_i,
   input  logic              p1_write_i,
   input  logic [ADDR_W-1:0] p1_addr_i,
   input  logic [LINE_W-1:0] p1_data_i,
   output logic              p1_ack_o,
   output logic [LINE_W-1:0] p1_data_o,
   output logic              mem_enable_o,
   output logic              mem_write_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [LINE_W-1:0] mem_data_o,
   input  logic              mem_ack_i,
   input  logic [LINE_W-1:0] mem_data_i,
   output logic              err_o
);

   state_t             r_state;
   logic               r_last;
   logic               r_sel;
   logic               r_write;
   logic [ADDR_W-1:0]  r_addr;
   logic [LINE_W-1:0]  r_data;
   logic [CNT_W-1:0]   r_wait_cnt;
   logic [1:0]         w_grant;
   logic               w_grant_p1;
   logic               w_timeout_hit;

   rr_arb2 u_rr_arb2 (
      .req_i   ({p1_enable_i, p0_enable_i}),
      .last_i  (r_last),
      .grant_o (w_grant)
   );

   assign w_grant_p1    = w_grant[1];
   assign w_timeout_hit = (int'(r_wait_cnt) + 1) >= TIMEOUT;

   assign mem_write_o = r_write;
   assign mem_addr_o  = r_addr;
   assign mem_data_o  = r_data;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state      <= IDLE;
         r_last       <= PORT1;
         r_sel        <= PORT0;
         r_write      <= 1'b0;
         r_addr       <= '0;
         r_data       <= '0;
         r_wait_cnt   <= '0;
         mem_enable_o <= 1'b0;
         p0_ack_o     <= 1'b0;
         p1_ack_o     <= 1'b0;
         p0_data_o    <= '0;
         p1_data_o    <= '0;
         err_o        <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (|w_grant) begin
                  r_sel        <= w_grant_p1;
                  r_last       <= w_grant_p1;
                  r_write      <= w_grant_p1 ? p1_write_i : p0_write_i;
                  r_addr       <= w_grant_p1 ? p1_addr_i  : p0_addr_i;
                  r_data       <= w_grant_p1 ? p1_data_i  : p0_data_i;
                  r_wait_cnt   <= '0;
                  mem_enable_o <= 1'b1;
                  r_state      <= BUSY;
               end
            end
            BUSY: begin
               if (mem_ack_i) begin
                  if (!r_write) begin
                     if (r_sel == PORT1) p1_data_o <= mem_data_i;
                     else                p0_data_o <= mem_data_i;
                  end
                  p0_ack_o     <= (r_sel == PORT0);
                  p1_ack_o     <= (r_sel == PORT1);
                  mem_enable_o <= 1'b0;
                  r_state      <= RESP;
               end else begin
                  // Keep waiting after a timeout; the flag only reports it.
                  if (r_wait_cnt != '1) r_wait_cnt <= r_wait_cnt + 1'b1;
                  if (w_timeout_hit)    err_o      <= 1'b1;
               end
            end
            RESP: begin
               p0_ack_o <= 1'b0;
               p1_ack_o <= 1'b0;
               r_state  <= IDLE;
            end
            default: begin
               p0_ack_o     <= 1'b0;
               p1_ack_o     <= 1'b0;
               mem_enable_o <= 1'b0;
               r_state      <= IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mem_arbiter : randomized bench with transaction-level reference   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_mem_arbiter;

   localparam int ADDR_W  = 32;
   localparam int LINE_W  = 256;
   localparam int TIMEOUT = 15;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              en [2];
   logic              wr [2];
   logic [ADDR_W-1:0] ad [2];
   logic [LINE_W-1:0] dt [2];
   logic              ack0, ack1, mem_en, mem_wr, mem_ack, err;
   logic [LINE_W-1:0] dout0, dout1, mem_dout, mem_din;
   logic [ADDR_W-1:0] mem_ad;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .TIMEOUT(TIMEOUT)) dut (
      .clk_i(clk), .rst_i(rst),
      .p0_enable_i(en[0]), .p0_write_i(wr[0]), .p0_addr_i(ad[0]), .p0_data_i(dt[0]),
      .p0_ack_o(ack0), .p0_data_o(dout0),
      .p1_enable_i(en[1]), .p1_write_i(wr[1]), .p1_addr_i(ad[1]), .p1_data_i(dt[1]),
      .p1_ack_o(ack1), .p1_data_o(dout1),
      .mem_enable_o(mem_en), .mem_write_o(mem_wr), .mem_addr_o(mem_ad),
      .mem_data_o(mem_dout), .mem_ack_i(mem_ack), .mem_data_i(mem_din),
      .err_o(err)
   );

   // Reference: who owns memory, who is being answered, and what each port should hold.
   int                owner      = -1;
   int                resp_owner = -1;
   bit                m_last     = 1'b1;
   int                waited, delay;
   int                next_delay = -1;
   bit                m_wr;
   logic [ADDR_W-1:0] m_ad;
   logic [LINE_W-1:0] m_dt, ack_line;
   logic [LINE_W-1:0] exp_d [2];
   bit                exp_err;
   logic [LINE_W-1:0] golden [logic [ADDR_W-1:0]];
   int                ack_log [$];
   bit                auto_req;
   bit                cont [2];
   int                n_checks = 0;
   int                n_errors = 0;

   task automatic check(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [LINE_W-1:0] rand_line();
      logic [LINE_W-1:0] l;
      for (int i = 0; i < LINE_W / 32; i++) l[i*32 +: 32] = $urandom;
      return l;
   endfunction

   task automatic issue(input int p, input bit w, input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] d);
      en[p] = 1'b1; wr[p] = w; ad[p] = a; dt[p] = d;
   endtask

   task automatic new_txn(input int p);
      issue(p, 1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 7) * 32), rand_line());
   endtask

   task automatic model_step();
      int p;
      if (resp_owner >= 0) begin
         resp_owner = -1;
      end else if (owner >= 0) begin
         if (mem_ack) begin
            if (!m_wr) exp_d[owner] = ack_line;
            resp_owner = owner;
            owner      = -1;
         end else begin
            waited++;
            if (waited >= TIMEOUT) exp_err = 1'b1;
         end
      end else if (en[0] || en[1]) begin
         p      = (en[0] && en[1]) ? (m_last ? 0 : 1) : (en[1] ? 1 : 0);
         m_last = p[0];
         m_wr   = wr[p]; m_ad = ad[p]; m_dt = dt[p];
         waited = 0;
         delay  = (next_delay >= 0) ? next_delay : $urandom_range(0, 6);
         next_delay = -1;
         owner  = p;
      end
   endtask

   task automatic compare_outputs();
      check("p0_ack", ack0, resp_owner == 0);
      check("p1_ack", ack1, resp_owner == 1);
      check("mem_en", mem_en, owner >= 0);
      if (owner >= 0) begin
         check("mem_addr", mem_ad, m_ad);
         check("mem_write", mem_wr, m_wr);
         if (m_wr) check("mem_wdata", mem_dout, m_dt);
      end
      check("p0_data", dout0, exp_d[0]);
      check("p1_data", dout1, exp_d[1]);
      check("err", err, exp_err);
   endtask

   task automatic drive_inputs();
      logic a;
      for (int p = 0; p < 2; p++) begin
         a = (p == 1) ? ack1 : ack0;
         if (a) begin
            ack_log.push_back(p);
            en[p] = 1'b0;
         end else if (owner == p) begin
            // Requester scribbles over its inputs once granted.
            wr[p] = 1'($urandom); ad[p] = $urandom; dt[p] = rand_line();
         end else if (!en[p] && (cont[p] || (auto_req && $urandom_range(0, 3) == 0))) begin
            new_txn(p);
         end
      end
      if (owner >= 0 && waited == delay) begin
         mem_ack = 1'b1;
         if (m_wr) begin
            golden[m_ad] = m_dt;
            ack_line     = rand_line();
         end else begin
            if (!golden.exists(m_ad)) golden[m_ad] = rand_line();
            ack_line = golden[m_ad];
         end
         mem_din = ack_line;
      end else begin
         mem_ack = (owner < 0) && ($urandom_range(0, 4) == 0);
         mem_din = rand_line();
      end
   endtask

   task automatic cycle();
      @(posedge clk); #1;
      model_step();
      compare_outputs();
      drive_inputs();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      check("rst_ack0", ack0, 1'b0);
      check("rst_ack1", ack1, 1'b0);
      check("rst_mem_en", mem_en, 1'b0);
      check("rst_mem_wr", mem_wr, 1'b0);
      check("rst_mem_addr", mem_ad, '0);
      check("rst_mem_data", mem_dout, '0);
      check("rst_dout0", dout0, '0);
      check("rst_dout1", dout1, '0);
      check("rst_err", err, 1'b0);
      en[0] = 1'b0; en[1] = 1'b0; mem_ack = 1'b0;
      cont[0] = 1'b0; cont[1] = 1'b0;
      owner = -1; resp_owner = -1; m_last = 1'b1; next_delay = -1;
      exp_d[0] = '0; exp_d[1] = '0; exp_err = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic wait_ack(input int p, input int limit);
      logic seen;
      int   k;
      seen = 1'b0;
      k    = 0;
      while (!seen && k < limit) begin
         cycle();
         seen = (p == 1) ? ack1 : ack0;
         k++;
      end
      check("ack_wait", seen, 1'b1);
   endtask

   task automatic wait_acks(input int n, input int limit);
      int k;
      k = 0;
      while (ack_log.size() < n && k < limit) begin
         cycle();
         k++;
      end
      check("ack_count", ack_log.size(), n);
   endtask

   initial begin
      logic [LINE_W-1:0] saved;
      for (int p = 0; p < 2; p++) begin
         en[p] = 1'b0; wr[p] = 1'b0; ad[p] = '0; dt[p] = '0;
         cont[p] = 1'b0; exp_d[p] = '0;
      end
      mem_ack = 1'b0; mem_din = '0; auto_req = 1'b0; exp_err = 1'b0;
      #2;
      do_reset();
      repeat (3) cycle();

      // Single read of a known line.
      golden[32'h40] = {32{8'hA5}};
      next_delay = 7;
      issue(0, 1'b0, 32'h40, rand_line());
      wait_ack(0, 40);
      check("rd_line", dout0, {32{8'hA5}});
      repeat (2) cycle();

      // Simultaneous requests straight after reset: p0 first.
      do_reset();
      ack_log.delete();
      issue(0, 1'b0, 32'h20, rand_line());
      issue(1, 1'b0, 32'h60, rand_line());
      wait_acks(2, 60);
      if (ack_log.size() >= 2) begin
         check("order_first", ack_log[0], 0);
         check("order_second", ack_log[1], 1);
      end

      // Continuous contention alternates.
      ack_log.delete();
      cont[0] = 1'b1; cont[1] = 1'b1;
      wait_acks(6, 150);
      cont[0] = 1'b0; cont[1] = 1'b0;
      for (int i = 0; i < 6 && i < ack_log.size(); i++) check("fair_order", ack_log[i], i % 2);
      repeat (30) cycle();

      // Write from p1 leaves its read line alone.
      saved = exp_d[1];
      issue(1, 1'b1, 32'h100, LINE_W'(32'h1234));
      wait_ack(1, 40);
      check("wr_keep_dout1", dout1, saved);
      check("wr_golden", golden[32'h100], LINE_W'(32'h1234));
      repeat (2) cycle();

      // Timeout: ack withheld 20 cycles, late ack still completes.
      next_delay = 20;
      issue(0, 1'b0, 32'h60, rand_line());
      wait_ack(0, 60);
      check("err_set", err, 1'b1);
      repeat (5) cycle();
      check("err_sticky", err, 1'b1);

      // Reset while BUSY abandons the transaction.
      next_delay = 10;
      issue(0, 1'b0, 32'h80, rand_line());
      repeat (4) cycle();
      check("busy_before_rst", mem_en, 1'b1);
      ack_log.delete();
      do_reset();
      repeat (15) cycle();
      check("no_ack_after_rst", ack_log.size(), 0);
      issue(1, 1'b0, 32'h20, rand_line());
      wait_ack(1, 40);

      // Random traffic from both ports.
      auto_req = 1'b1;
      repeat (400) cycle();
      auto_req = 1'b0;
      repeat (40) cycle();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, requester/memory address width.
REQ-002 SHALL have parameter LINE_W, default 256, cache-line data width.
REQ-003 SHALL have parameter TIMEOUT, default 15, maximum BUSY cycles awaiting mem_ack_i before flagging error.
REQ-004 SHALL have one clock and an asynchronous, active-high reset, as listed below.
REQ-005 SHALL have ports:
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  asynchronous active-high reset
- p0_enable_i  in  1  port 0 (data cache) request, held until p0_ack_o
- p0_write_i  in  1  port 0 1=write, 0=read
- p0_addr_i  in  ADDR_W  port 0 byte address
- p0_data_i  in  LINE_W  port 0 write line
- p0_ack_o  out  1  port 0 one-cycle completion pulse
- p0_data_o  out  LINE_W  port 0 read line
- p1_enable_i, p1_write_i, p1_addr_i, p1_data_i, p1_ack_o, p1_data_o  port 1 (instruction cache), same widths and meanings
- mem_enable_o  out  1  memory request
- mem_write_o  out  1  memory write select
- mem_addr_o  out  ADDR_W  memory address
- mem_data_o  out  LINE_W  memory write line
- mem_ack_i  in  1  memory one-cycle completion pulse
- mem_data_i  in  LINE_W  memory read line
- err_o  out  1  sticky timeout flag

Function
REQ-006 SHALL implement states IDLE, BUSY, RESP.
REQ-007 In IDLE with any enable high, SHALL grant one port, latch its write/addr/data into internal registers, and move to BUSY next cycle.
REQ-008 Arbitration SHALL be round-robin: on simultaneous requests, grant the port not granted last; the last-grant pointer updates on each grant.
REQ-009 With one request, SHALL grant it regardless of pointer.
REQ-010 In BUSY, SHALL drive mem_enable_o=1 and mem_write_o/mem_addr_o/mem_data_o from latched registers, stable for the whole state.
REQ-011 In BUSY with mem_ack_i=1, SHALL capture mem_data_i into the granted port's data register on a read, leave it unchanged on a write, and move to RESP.
REQ-012 In RESP, SHALL drive mem_enable_o=0, assert the granted port's ack_o for exactly one cycle, and return to IDLE.
REQ-013 p*_data_o SHALL be valid in the RESP cycle and hold until that port's next read completes.
REQ-014 The non-granted port's ack_o SHALL remain 0; its request SHALL wait unaffected.
REQ-015 Changes to requester inputs after grant SHALL NOT affect the in-flight transaction.
REQ-016 mem_ack_i outside BUSY SHALL be ignored.
REQ-017 A 4-bit wait counter SHALL clear on entry to BUSY and increment each BUSY cycle without mem_ack_i, saturating.
REQ-018 When the counter reaches TIMEOUT, err_o SHALL set and stay set until reset; the FSM SHALL remain in BUSY awaiting mem_ack_i.
REQ-019 Minimum turnaround SHALL be 3 cycles from grant to the next possible grant (IDLE, BUSY, RESP).

Reset
REQ-020 rst_i high SHALL immediately force state IDLE, all ack_o=0, mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0, p*_data_o=0, err_o=0, counter=0, and pointer favouring port 0.
REQ-021 Reset during BUSY or RESP SHALL abandon the transaction with no ack to either port.

Structure
REQ-022 State encoding (2-bit) and the port index constants SHALL live in a shared package, mem_pkg.
REQ-023 The round-robin pick SHALL be a sub-module, rr_arb2, taking two requests and the pointer and returning a one-hot grant.

Verification
REQ-024 Single read: p0 read addr 0x40, memory acks after 7 cycles with line 0xA5..A5 -> mem_addr_o=0x40, one p0_ack_o pulse, p0_data_o=0xA5..A5.
REQ-025 Simultaneous: p0 and p1 request in the same cycle after reset -> p0 served first, p1 granted in the next IDLE, two acks in order p0 then p1.
REQ-026 Fairness: both ports request continuously for 6 transactions -> grants alternate p0,p1,p0,p1,p0,p1.
REQ-027 Write: p1 write addr 0x100, data 0x1234 -> mem_write_o=1, mem_data_o=0x1234 throughout BUSY, p1_data_o unchanged.
REQ-028 Timeout: mem_ack_i withheld 20 cycles -> err_o rises after 15 BUSY cycles, a late ack still completes normally, err_o stays 1.
REQ-029 Reset mid-BUSY: rst_i pulsed during BUSY -> all outputs 0 that cycle, no ack issued, next request granted normally.
